// File: rtl/mux_arbiter_if.sv
// Request/grant bundle between the arbiter and its two requesters.
// The master side is the arbiter; the slave side is the requester pair.
interface mux_arbiter_if #(
  parameter int CNT_WIDTH = 5
) ();
  logic [1:0]           req;
  logic [1:0]           grant;
  logic                 sel;
  logic                 busy;
  logic [CNT_WIDTH-1:0] hold_cnt;

  modport master (
    input  req,
    output grant,
    output sel,
    output busy,
    output hold_cnt
  );

  modport slave (
    output req,
    input  grant,
    input  sel,
    input  busy,
    input  hold_cnt
  );
endinterface

// File: rtl/mux_arbiter.sv
// Two-way round-robin arbiter owning a shared 2:1 mux select; grant is registered (1 cycle from req).
// A contended owner is preempted after HOLD_MAX granted cycles; HOLD_MAX=0 lets an owner keep it forever.
module mux_arbiter #(
  parameter int HOLD_MAX  = 16,
  parameter int CNT_WIDTH = 5
) (
  input logic          clk,
  input logic          reset,
  mux_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
    (HOLD_MAX == 0) ? '0 : CNT_WIDTH'(HOLD_MAX - 1);
  localparam bit PREEMPT_EN = (HOLD_MAX != 0);

  state_t               r_state;
  state_t               w_next;
  state_t               w_other;
  logic                 r_last;
  logic                 r_sel;
  logic                 r_busy;
  logic [1:0]           r_grant;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_cur;
  logic                 w_own_req;
  logic                 w_oth_req;
  logic                 w_limit;
  logic                 w_next_idx;

  always_comb begin
    w_next     = r_state;
    w_cur      = (r_state == OWN1);
    w_other    = w_cur ? OWN0 : OWN1;
    w_own_req  = bus.req[w_cur];
    w_oth_req  = bus.req[~w_cur];
    // >= so an owner that was uncontended past the limit yields on the first contended edge
    w_limit    = PREEMPT_EN && (r_cnt >= HOLD_LAST);
    w_next_idx = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.req == 2'b11)
          w_next = r_last ? OWN0 : OWN1;
        else if (bus.req[0])
          w_next = OWN0;
        else if (bus.req[1])
          w_next = OWN1;
      end
      OWN0, OWN1: begin
        if (!w_own_req)
          w_next = w_oth_req ? w_other : IDLE;
        else if (w_oth_req && w_limit)
          w_next = w_other;
      end
      default: w_next = IDLE;
    endcase

    w_next_idx = (w_next == OWN1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_sel   <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == IDLE) begin
        r_grant <= 2'b00;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_grant <= w_next_idx ? 2'b10 : 2'b01;
        r_busy  <= 1'b1;
        r_sel   <= w_next_idx;
        if (w_next != r_state) begin
          r_cnt  <= '0;
          r_last <= w_next_idx;
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.grant    = r_grant;
  assign bus.sel      = r_sel;
  assign bus.busy     = r_busy;
  assign bus.hold_cnt = r_cnt;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against an ownership model.
// dut_a uses HOLD_MAX=16, dut_b uses HOLD_MAX=0.
module tb_mux_arbiter;

  localparam int CW      = 5;
  localparam int SAT     = (1 << CW) - 1;
  localparam int HOLD_A  = 16;
  localparam int HOLD_B  = 0;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  // model state per DUT: owner -1 means nobody
  int m_own  [2];
  int m_last [2];
  int m_sel  [2];
  int m_cnt  [2];

  logic [1:0] prev_ra;
  int         wait_cnt [2];

  mux_arbiter_if #(.CNT_WIDTH(CW)) ifa ();
  mux_arbiter_if #(.CNT_WIDTH(CW)) ifb ();

  mux_arbiter #(.HOLD_MAX(HOLD_A), .CNT_WIDTH(CW)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  mux_arbiter #(.HOLD_MAX(HOLD_B), .CNT_WIDTH(CW)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void take(input int d, input int who);
    m_own[d]  = who;
    m_last[d] = who;
    m_sel[d]  = who;
    m_cnt[d]  = 0;
  endfunction

  function automatic void model_step(input int d, input logic [1:0] r, input bit rst, input int hold);
    int k;
    int o;
    if (rst) begin
      m_own[d]  = -1;
      m_last[d] = 1;
      m_sel[d]  = 0;
      m_cnt[d]  = 0;
      return;
    end
    if (m_own[d] < 0) begin
      if (r == 2'b11)      take(d, 1 - m_last[d]);
      else if (r[0])       take(d, 0);
      else if (r[1])       take(d, 1);
      return;
    end
    k = m_own[d];
    o = 1 - k;
    if (!r[k]) begin
      if (r[o]) take(d, o);
      else begin
        m_own[d] = -1;
        m_cnt[d] = 0;
      end
    end else if (r[o] && hold != 0 && m_cnt[d] + 1 >= hold) begin
      take(d, o);
    end else begin
      m_cnt[d] = (m_cnt[d] < SAT) ? m_cnt[d] + 1 : SAT;
    end
  endfunction

  task automatic cmp_dut(input string who, input int d, input logic [1:0] g, input logic s,
                         input logic b, input logic [CW-1:0] c);
    logic [1:0] eg;
    eg = (m_own[d] < 0) ? 2'b00 : (m_own[d] == 0 ? 2'b01 : 2'b10);
    check({who, "_grant"}, 32'(g), 32'(eg));
    check({who, "_sel"},   32'(s), 32'(m_sel[d]));
    check({who, "_busy"},  32'(b), 32'(m_own[d] >= 0));
    check({who, "_cnt"},   32'(c), 32'(m_cnt[d]));
  endtask

  task automatic step();
    logic [1:0] ra;
    logic [1:0] rb;
    bit         rs;
    ra = ifa.req;
    rb = ifb.req;
    rs = reset;
    @(posedge clk);
    #1;
    model_step(0, ra, rs, HOLD_A);
    model_step(1, rb, rs, HOLD_B);
    cmp_dut("a", 0, ifa.grant, ifa.sel, ifa.busy, ifa.hold_cnt);
    cmp_dut("b", 1, ifb.grant, ifb.sel, ifb.busy, ifb.hold_cnt);
    prev_ra = ra;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    ifa.req  = 2'b00;
    ifb.req  = 2'b00;
    wait_cnt[0] = 0;
    wait_cnt[1] = 0;

    // reset values
    step();
    step();
    check("rst_grant", 32'(ifa.grant), 32'h0);
    check("rst_cnt",   32'(ifa.hold_cnt), 32'h0);
    reset = 1'b0;

    // single requester, held three cycles
    ifa.req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_grant", 32'(ifa.grant), 32'h1);
      check("t1_cnt",   32'(ifa.hold_cnt), 32'(i));
    end
    ifa.req = 2'b00;
    step();
    check("t1_release", 32'(ifa.grant), 32'h0);
    check("t1_sel_keep", 32'(ifa.sel), 32'h0);

    // contention from fresh reset: requester 0 first, exactly 16 cycles each
    reset = 1'b1;
    step();
    reset = 1'b0;
    ifa.req = 2'b11;
    for (int i = 0; i < HOLD_A; i++) begin
      step();
      check("t2_own0", 32'(ifa.grant), 32'h1);
      check("t2_cnt0", 32'(ifa.hold_cnt), 32'(i));
    end
    for (int i = 0; i < HOLD_A; i++) begin
      step();
      check("t2_own1", 32'(ifa.grant), 32'h2);
      check("t2_sel1", 32'(ifa.sel), 32'h1);
    end
    step();
    check("t2_back0", 32'(ifa.grant), 32'h1);

    // direct handoff without an idle gap
    ifa.req = 2'b10;
    step();
    check("t3_own1", 32'(ifa.grant), 32'h2);
    ifa.req = 2'b01;
    step();
    check("t3_grant", 32'(ifa.grant), 32'h1);
    check("t3_sel",   32'(ifa.sel), 32'h0);
    check("t3_cnt",   32'(ifa.hold_cnt), 32'h0);

    // reset during OWN1 with both requesting
    ifa.req = 2'b10;
    step();
    ifa.req = 2'b11;
    reset = 1'b1;
    step();
    check("t5_grant", 32'(ifa.grant), 32'h0);
    check("t5_sel",   32'(ifa.sel), 32'h0);
    check("t5_busy",  32'(ifa.busy), 32'h0);
    reset = 1'b0;
    step();
    check("t5_regrant", 32'(ifa.grant), 32'h1);

    // preemption disabled: owner keeps it, counter saturates
    ifb.req = 2'b11;
    for (int i = 0; i < 40; i++) begin
      step();
      check("t4_grant", 32'(ifb.grant), 32'h1);
    end
    check("t4_sat", 32'(ifb.hold_cnt), 32'(SAT));
    ifb.req = 2'b00;

    // random traffic with sticky requests so contention runs get long
    ifa.req = 2'b00;
    step();
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) ifa.req[0] = ~ifa.req[0];
      if ($urandom_range(0, 3) == 0) ifa.req[1] = ~ifa.req[1];
      if ($urandom_range(0, 7) == 0) ifb.req = 2'($urandom_range(0, 3));
      step();
      check("r_not_both", 32'(ifa.grant == 2'b11), 32'h0);
      check("r_busy_or",  32'(ifa.busy), 32'(|ifa.grant));
      if (ifa.busy) check("r_sel_idx", 32'(ifa.sel), 32'(ifa.grant[1]));
      for (int k = 0; k < 2; k++) begin
        if (prev_ra[k] && !ifa.grant[k]) wait_cnt[k]++;
        else wait_cnt[k] = 0;
        check("r_wait", 32'(wait_cnt[k] <= HOLD_A + 1), 32'h1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
